// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: source select and load size.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2,
    WB_IMM  = 2'd3
  } wb_sel_e;

  // Code 3 is illegal and behaves as a full-word load.
  typedef enum logic [1:0] {
    LD_WORD = 2'd0,
    LD_HALF = 2'd1,
    LD_BYTE = 2'd2,
    LD_RSVD = 2'd3
  } ld_size_e;

endpackage

// File: rtl/load_align.sv
// Little-endian sub-word load extraction with sign/zero extension and
// misalignment detection. Purely combinational.
module load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_off,
  input  ld_size_e          i_size,
  input  logic              i_signed,
  output logic [DATA_W-1:0] o_data,
  output logic              o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    w_byte     = i_word[{i_off, 3'b000} +: 8];
    w_half     = i_off[1] ? i_word[31:16] : i_word[15:0];
    o_data     = i_word;
    o_misalign = (i_off != 2'b00);
    case (i_size)
      LD_HALF: begin
        o_data     = {{(DATA_W-16){i_signed & w_half[15]}}, w_half};
        o_misalign = i_off[0];
      end
      LD_BYTE: begin
        o_data     = {{(DATA_W-8){i_signed & w_byte[7]}}, w_byte};
        o_misalign = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage_pipelined.sv
// Writeback stage: MEM/WB pipeline register, source mux, load alignment,
// register-file write port, forwarding bus and retired-instruction counter.
module wb_stage_pipelined
  import wb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid,
  input  logic [DATA_W-1:0]     mem_read_data,
  input  logic [DATA_W-1:0]     mem_alu_result,
  input  logic [DATA_W-1:0]     mem_link_addr,
  input  logic [DATA_W-1:0]     mem_imm,
  input  logic [1:0]            mem_wb_sel,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_write_reg,
  input  logic [1:0]            mem_load_size,
  input  logic                  mem_load_signed,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0]     fwd_data,
  output logic                  align_err,
  output logic [CNT_W-1:0]      retired_count
);

  logic                  r_valid;
  logic [DATA_W-1:0]     r_read_data;
  logic [DATA_W-1:0]     r_alu_result;
  logic [DATA_W-1:0]     r_link_addr;
  logic [DATA_W-1:0]     r_imm;
  wb_sel_e               r_wb_sel;
  logic                  r_reg_write;
  logic [REG_ADDR_W-1:0] r_write_reg;
  ld_size_e              r_load_size;
  logic                  r_load_signed;
  logic [CNT_W-1:0]      r_retired;

  logic [DATA_W-1:0]     w_load_data;
  logic                  w_misalign;
  logic [DATA_W-1:0]     w_wdata;
  logic                  w_align_err;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)        r_valid <= 1'b0;
    else if (flush) r_valid <= 1'b0;
    else if (!stall) r_valid <= mem_valid;
  end

  // The held instruction leaves on any non-stalled edge, flush included.
  always_ff @(posedge clk) begin
    if (rst)                    r_retired <= '0;
    else if (r_valid && !stall) r_retired <= r_retired + CNT_W'(1);
  end

  // NOTE: payload flops carry no reset; r_valid gates every use of them.
  always_ff @(posedge clk) begin
    if (!stall) begin
      r_read_data   <= mem_read_data;
      r_alu_result  <= mem_alu_result;
      r_link_addr   <= mem_link_addr;
      r_imm         <= mem_imm;
      r_wb_sel      <= wb_sel_e'(mem_wb_sel);
      r_reg_write   <= mem_reg_write;
      r_write_reg   <= mem_write_reg;
      r_load_size   <= ld_size_e'(mem_load_size);
      r_load_signed <= mem_load_signed;
    end
  end

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .i_word     (r_read_data),
    .i_off      (r_alu_result[1:0]),
    .i_size     (r_load_size),
    .i_signed   (r_load_signed),
    .o_data     (w_load_data),
    .o_misalign (w_misalign)
  );

  always_comb begin
    w_wdata = r_alu_result;
    case (r_wb_sel)
      WB_MEM:  w_wdata = w_load_data;
      WB_LINK: w_wdata = r_link_addr;
      WB_IMM:  w_wdata = r_imm;
      default: ;
    endcase
  end

  assign w_align_err   = r_valid & (r_wb_sel == WB_MEM) & w_misalign;
  assign align_err     = w_align_err;
  assign rf_we         = r_valid & r_reg_write & (r_write_reg != '0) & ~w_align_err;
  assign rf_waddr      = r_valid ? r_write_reg : '0;
  assign rf_wdata      = r_valid ? w_wdata : '0;
  assign fwd_valid     = rf_we;
  assign fwd_addr      = rf_waddr;
  assign fwd_data      = rf_wdata;
  assign retired_count = r_retired;

endmodule
